// File: rtl/brg_pkg.sv
// Shared constants for the fractional UART baud-rate generator.
package brg_pkg;

  localparam int unsigned CLK_FREQ_HZ = 16_000_000;

  localparam int unsigned BAUD_9600   = 9_600;
  localparam int unsigned BAUD_57600  = 57_600;
  localparam int unsigned BAUD_115200 = 115_200;

  localparam int unsigned DEF_OSR    = 16;
  localparam int unsigned DEF_FRAC_W = 4;

  // Divisor clk / (osr * baud) as fixed point with frac_w fraction bits, rounded to nearest.
  function automatic int unsigned calc_div_fx(input int unsigned clk_hz,
                                              input int unsigned baud,
                                              input int unsigned osr,
                                              input int unsigned frac_w);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_hz) << frac_w;
    den = 64'(osr) * 64'(baud);
    return 32'((64'd2 * num + den) / (64'd2 * den));
  endfunction

  localparam int unsigned DIV_9600_FX   = calc_div_fx(CLK_FREQ_HZ, BAUD_9600, DEF_OSR, DEF_FRAC_W);
  localparam int unsigned DIV_57600_FX  = calc_div_fx(CLK_FREQ_HZ, BAUD_57600, DEF_OSR, DEF_FRAC_W);
  localparam int unsigned DIV_115200_FX = calc_div_fx(CLK_FREQ_HZ, BAUD_115200, DEF_OSR,
                                                      DEF_FRAC_W);

  // 104 + 3/16
  localparam int unsigned DIV_9600_INT    = DIV_9600_FX >> DEF_FRAC_W;
  localparam int unsigned DIV_9600_FRAC   = DIV_9600_FX % (2 ** DEF_FRAC_W);
  // 17 + 6/16
  localparam int unsigned DIV_57600_INT   = DIV_57600_FX >> DEF_FRAC_W;
  localparam int unsigned DIV_57600_FRAC  = DIV_57600_FX % (2 ** DEF_FRAC_W);
  // 8 + 11/16
  localparam int unsigned DIV_115200_INT  = DIV_115200_FX >> DEF_FRAC_W;
  localparam int unsigned DIV_115200_FRAC = DIV_115200_FX % (2 ** DEF_FRAC_W);

endpackage

// File: rtl/brg_frac_div.sv
// Interval counter with fractional accumulator; emits the raw (unregistered) rx strobe.
module brg_frac_div
  import brg_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_act_int,
  input  logic [FRAC_W-1:0] i_act_frac,
  input  logic              i_clr_frac,  // divisor apply: restart accumulator and carry
  output logic              o_strobe
);

  localparam int unsigned P_W = DIV_W + 1;

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;

  logic [DIV_W-1:0]  w_eff_int;
  logic [P_W-1:0]    w_last;
  logic [FRAC_W:0]   w_sum;

  // Interval length is the clamped integer divisor plus the carry from the previous tick.
  always_comb begin
    w_eff_int = (i_act_int == '0) ? DIV_W'(1) : i_act_int;
    w_last    = {1'b0, w_eff_int} + P_W'(r_carry) - P_W'(1);
    w_sum     = {1'b0, r_acc} + {1'b0, i_act_frac};
    o_strobe  = i_en & ({1'b0, r_cnt} == w_last);
  end

  // Counter, accumulator and carry; everything clears while disabled.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (o_strobe) begin
      r_cnt <= '0;
      if (i_clr_frac) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
      end else begin
        r_acc   <= w_sum[FRAC_W-1:0];
        r_carry <= w_sum[FRAC_W];
      end
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/brg_frac.sv
// Fractional baud-rate generator: shadowed divisor, rx oversampling tick, tx bit tick, phase.
module brg_frac
  import brg_pkg::*;
#(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned FRAC_W   = DEF_FRAC_W,
  parameter int unsigned OSR      = DEF_OSR,  // must be >= 2
  parameter int unsigned DEF_INT  = DIV_115200_INT,
  parameter int unsigned DEF_FRAC = DIV_115200_FRAC
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [DIV_W-1:0]       i_div_int,
  input  logic [FRAC_W-1:0]      i_div_frac,
  input  logic                   i_div_load,
  output logic                   o_cfg_pending,
  output logic                   o_rx_tick,
  output logic                   o_tx_tick,
  output logic [$clog2(OSR)-1:0] o_rx_phase
);

  localparam int unsigned     PH_W   = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(OSR - 1);

  logic [DIV_W-1:0]  r_sh_int;
  logic [FRAC_W-1:0] r_sh_frac;
  logic [DIV_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic              r_pending;
  logic              r_rx_tick;
  logic              r_tx_tick;
  logic [PH_W-1:0]   r_phase;

  logic              w_strobe;
  logic              w_apply;
  logic [PH_W-1:0]   w_phase_next;

  brg_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_act_int  (r_act_int),
    .i_act_frac (r_act_frac),
    .i_clr_frac (w_apply),
    .o_strobe   (w_strobe)
  );

  // Apply on an rx tick edge, or straight away while the generator is idle.
  assign w_apply = r_pending & (w_strobe | ~i_en);

  // Phase advances on the edge closing an rx tick cycle, so rx_phase names the tick it shows.
  always_comb begin
    w_phase_next = r_phase;
    if (r_rx_tick) begin
      w_phase_next = (r_phase == PH_MAX) ? '0 : r_phase + PH_W'(1);
    end
  end

  // Shadow capture, pending flag and shadow-to-active transfer; a load beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sh_int   <= DIV_W'(DEF_INT);
      r_sh_frac  <= FRAC_W'(DEF_FRAC);
      r_act_int  <= DIV_W'(DEF_INT);
      r_act_frac <= FRAC_W'(DEF_FRAC);
      r_pending  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      if (i_div_load) begin
        r_sh_int  <= i_div_int;
        r_sh_frac <= i_div_frac;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Registered ticks and phase; tx tick marks the last rx tick of each bit.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
      r_phase   <= '0;
    end else begin
      r_rx_tick <= w_strobe;
      r_tx_tick <= w_strobe & (w_phase_next == PH_MAX);
      r_phase   <= w_phase_next;
    end
  end

  assign o_cfg_pending = r_pending;
  assign o_rx_tick     = r_rx_tick;
  assign o_tx_tick     = r_tx_tick;
  assign o_rx_phase    = r_phase;

endmodule

// File: tb/tb_brg_frac.sv
// Self-checking bench for brg_frac: directed test-plan scenarios plus random traffic,
// compared every cycle against a tick-interval reference model.
module tb_brg_frac;

  localparam int OSR    = 16;
  localparam int FRAC_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] dint;
  logic [3:0]  dfrac;
  logic        pend;
  logic        rx;
  logic        tx;
  logic [3:0]  ph;

  always #5 clk = ~clk;

  brg_frac #(
    .DIV_W    (16),
    .FRAC_W   (FRAC_W),
    .OSR      (OSR),
    .DEF_INT  (8),
    .DEF_FRAC (11)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_div_int     (dint),
    .i_div_frac    (dfrac),
    .i_div_load    (load),
    .o_cfg_pending (pend),
    .o_rx_tick     (rx),
    .o_tx_tick     (tx),
    .o_rx_phase    (ph)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each interval lasts max(int,1)+carry edges; carry comes from the
  // fractional sum taken at the previous tick.
  int m_act_int, m_act_frac, m_sh_int, m_sh_frac, m_pend;
  int m_acc, m_carry, m_elapsed, m_phase, m_rx, m_tx;

  function automatic void model_edge();
    int period;
    int sum;
    if (rst) begin
      m_act_int = 8;  m_act_frac = 11;
      m_sh_int  = 8;  m_sh_frac  = 11;
      m_pend = 0; m_acc = 0; m_carry = 0; m_elapsed = 0;
      m_phase = 0; m_rx = 0; m_tx = 0;
      return;
    end
    if (!en) begin
      if (m_pend != 0) begin
        m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pend = 0;
      end
      m_acc = 0; m_carry = 0; m_elapsed = 0; m_phase = 0; m_rx = 0; m_tx = 0;
    end else begin
      if (m_rx != 0) m_phase = (m_phase + 1) % OSR;
      m_elapsed++;
      period = ((m_act_int == 0) ? 1 : m_act_int) + m_carry;
      m_rx = (m_elapsed == period) ? 1 : 0;
      m_tx = (m_rx != 0 && m_phase == OSR - 1) ? 1 : 0;
      if (m_rx != 0) begin
        m_elapsed = 0;
        if (m_pend != 0) begin
          m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pend = 0;
          m_acc = 0; m_carry = 0;
        end else begin
          sum     = m_acc + m_act_frac;
          m_carry = sum / (1 << FRAC_W);
          m_acc   = sum % (1 << FRAC_W);
        end
      end
    end
    if (load) begin
      m_sh_int = int'(dint); m_sh_frac = int'(dfrac); m_pend = 1;
    end
  endfunction

  // One clock: model steps on the edge, DUT outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rx_tick", int'(rx), m_rx);
    check("tx_tick", int'(tx), m_tx);
    check("rx_phase", int'(ph), m_phase);
    check("cfg_pending", int'(pend), m_pend);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Bounded wait for the next rx (want_tx=0) or tx tick; n = cycles taken, nrx = rx ticks seen.
  task automatic run_until(input bit want_tx, input int limit, input string tag,
                           output int n, output int nrx);
    bit hit;
    n = 0; nrx = 0; hit = 1'b0;
    while (!hit && n < limit) begin
      cycle();
      n++;
      if (rx) nrx++;
      hit = want_tx ? tx : rx;
    end
    if (!hit) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic load_div(input int i, input int f);
    load = 1'b1; dint = 16'(i); dfrac = 4'(f);
    cycle();
    load = 1'b0;
  endtask

  // Load with the generator idle so the new divisor is active from a cleared state.
  task automatic idle_load(input int i, input int f);
    en = 1'b0;
    load_div(i, f);
    cycle();
  endtask

  int n, nrx;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; dint = '0; dfrac = '0;
    run_cycles(2);
    check("reset_rx", int'(rx), 0);
    check("reset_tx", int'(tx), 0);
    check("reset_phase", int'(ph), 0);
    check("reset_pending", int'(pend), 0);

    // Defaults 8/11: first rx after 8 edges, first tx after 138, then every 139.
    rst = 1'b0; en = 1'b1;
    run_until(0, 50, "def_rx", n, nrx);
    check("def_first_rx", n, 8);
    run_until(1, 300, "def_tx", n, nrx);
    check("def_first_tx", n + 8, 138);
    run_until(1, 300, "def_tx2", n, nrx);
    check("def_tx_period", n, 139);
    check("def_rx_per_tx", nrx, 16);

    // Integer divisor 4/0.
    idle_load(4, 0);
    en = 1'b1;
    run_until(0, 50, "int_rx", n, nrx);
    check("int_first_rx", n, 4);
    run_until(0, 50, "int_rx2", n, nrx);
    check("int_rx_period", n, 4);
    run_until(1, 200, "int_tx", n, nrx);
    run_until(1, 200, "int_tx2", n, nrx);
    check("int_tx_period", n, 64);

    // Divisor 1 and clamped 0.
    idle_load(1, 0);
    en = 1'b1;
    run_until(0, 10, "one_rx", n, nrx);
    check("one_first_rx", n, 1);
    run_until(1, 50, "one_tx", n, nrx);
    check("one_first_tx", n + 1, 16);
    run_until(1, 50, "one_tx2", n, nrx);
    check("one_tx_period", n, 16);
    idle_load(0, 0);
    en = 1'b1;
    run_until(0, 10, "zero_rx", n, nrx);
    check("zero_first_rx", n, 1);
    run_until(1, 50, "zero_tx", n, nrx);
    run_until(1, 50, "zero_tx2", n, nrx);
    check("zero_tx_period", n, 16);
    check("zero_rx_per_tx", nrx, 16);

    // Mid-run load at 8/11.
    idle_load(8, 11);
    en = 1'b1;
    run_cycles(13);
    load_div(20, 0);
    check("mid_pending", int'(pend), 1);
    run_until(0, 50, "mid_apply", n, nrx);
    check("mid_pending_clr", int'(pend), 0);
    run_until(0, 50, "mid_rx", n, nrx);
    check("mid_rx_period", n, 20);
    load_div(30, 0);
    load_div(20, 0);
    run_until(0, 50, "dbl_apply", n, nrx);
    run_until(0, 50, "dbl_rx", n, nrx);
    check("dbl_rx_period", n, 20);

    // Enable drop mid-bit, then restart identical to first run.
    idle_load(8, 11);
    en = 1'b1;
    run_cycles(50);
    en = 1'b0;
    run_cycles(5);
    check("drop_phase", int'(ph), 0);
    en = 1'b1;
    run_until(0, 50, "drop_rx", n, nrx);
    check("drop_first_rx", n, 8);
    run_until(1, 300, "drop_tx", n, nrx);
    check("drop_first_tx", n + 8, 138);

    // Reset mid-interval with a pending load.
    idle_load(4, 0);
    en = 1'b1;
    run_cycles(22);
    load_div(20, 0);
    cycle();
    rst = 1'b1;
    cycle();
    check("mrst_rx", int'(rx), 0);
    check("mrst_tx", int'(tx), 0);
    check("mrst_phase", int'(ph), 0);
    check("mrst_pending", int'(pend), 0);
    rst = 1'b0;
    run_until(0, 50, "mrst_rx", n, nrx);
    check("mrst_first_rx", n, 8);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 19) != 0);
      load  = ($urandom_range(0, 29) == 0);
      dint  = 16'($urandom_range(0, 5));
      dfrac = 4'($urandom);
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
